// File: rtl/apb_timer.sv
// APB timer: prescaled auto-reload up-counter with a sticky overflow flag, one wait state per transfer.
// Define APB_TIMER_IRQ_EN to implement CTRL.IE and drive irq = OVF & IE; otherwise irq is tied low.
module apb_timer #(
    parameter int WIDTH = 32
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        irq
);
    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_PSC  = 2'd1;
    localparam logic [1:0] ADDR_ARR  = 2'd2;
    localparam logic [1:0] ADDR_CNT  = 2'd3;

    logic             pready_q, pready_d;
    logic [31:0]      prdata_q, prdata_d;
    logic             en_q, en_d;
    logic             ovf_q, ovf_d;
    logic             ie_s;
    logic [WIDTH-1:0] psc_q, psc_d;
    logic [WIDTH-1:0] arr_q, arr_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] psc_cnt_q, psc_cnt_d;

    logic        wr_s, wr_ctrl_s, clr_s, ovf_w1c_s, tick_s, wrap_s;
    logic [31:0] rdata_s;
    logic        unused_s;

    assign wr_s      = PSEL & PENABLE & pready_q & PWRITE;
    assign wr_ctrl_s = wr_s & (PADDR[3:2] == ADDR_CTRL);
    assign clr_s     = wr_ctrl_s & PWDATA[1];
    assign ovf_w1c_s = wr_ctrl_s & PWDATA[8];
    // Counting sees the pre-write register values; a CLR swallows any coincident tick.
    assign tick_s    = en_q & (psc_cnt_q >= psc_q) & ~clr_s;
    assign wrap_s    = tick_s & (cnt_q >= arr_q);
    assign unused_s  = ^{PADDR[31:4], PADDR[1:0], PWDATA};

`ifdef APB_TIMER_IRQ_EN
    logic ie_q, ie_d;

    // Interrupt-enable register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ie_q <= 1'b0;
        end else begin
            ie_q <= ie_d;
        end
    end

    // Interrupt-enable next state
    always_comb begin
        if (wr_ctrl_s) begin
            ie_d = PWDATA[2];
        end else begin
            ie_d = ie_q;
        end
    end

    assign ie_s = ie_q;
`else
    assign ie_s = 1'b0;
`endif

    assign irq    = ovf_q & ie_s;
    assign PREADY = pready_q;
    assign PRDATA = prdata_q;

    // Next-state logic for handshake, registers, counters and read data
    always_comb begin
        pready_d = PSEL & PENABLE & ~pready_q;

        if (wr_ctrl_s) begin
            en_d = PWDATA[0];
        end else begin
            en_d = en_q;
        end

        if (wr_s && (PADDR[3:2] == ADDR_PSC)) begin
            psc_d = PWDATA[WIDTH-1:0];
        end else begin
            psc_d = psc_q;
        end

        if (wr_s && (PADDR[3:2] == ADDR_ARR)) begin
            arr_d = PWDATA[WIDTH-1:0];
        end else begin
            arr_d = arr_q;
        end

        if (clr_s || tick_s) begin
            psc_cnt_d = {WIDTH{1'b0}};
        end else if (en_q) begin
            psc_cnt_d = psc_cnt_q + WIDTH'(1);
        end else begin
            psc_cnt_d = psc_cnt_q;
        end

        if (clr_s || wrap_s) begin
            cnt_d = {WIDTH{1'b0}};
        end else if (tick_s) begin
            cnt_d = cnt_q + WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end

        // A set on the same edge as a W1C wins so no overflow is lost.
        ovf_d = wrap_s | (ovf_q & ~ovf_w1c_s);

        case (PADDR[3:2])
            ADDR_CTRL: rdata_s = {23'd0, ovf_q, 5'd0, ie_s, 1'b0, en_q};
            ADDR_PSC:  rdata_s = 32'(psc_q);
            ADDR_ARR:  rdata_s = 32'(arr_q);
            ADDR_CNT:  rdata_s = 32'(cnt_q);
            default:   rdata_s = 32'd0;
        endcase

        if (pready_d) begin
            prdata_d = rdata_s;
        end else begin
            prdata_d = 32'd0;
        end
    end

    // State registers
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            pready_q  <= 1'b0;
            prdata_q  <= 32'd0;
            en_q      <= 1'b0;
            ovf_q     <= 1'b0;
            psc_q     <= {WIDTH{1'b0}};
            arr_q     <= {WIDTH{1'b0}};
            cnt_q     <= {WIDTH{1'b0}};
            psc_cnt_q <= {WIDTH{1'b0}};
        end else begin
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            en_q      <= en_d;
            ovf_q     <= ovf_d;
            psc_q     <= psc_d;
            arr_q     <= arr_d;
            cnt_q     <= cnt_d;
            psc_cnt_q <= psc_cnt_d;
        end
    end
endmodule

// File: tb/tb_apb_timer.sv
// Directed bench for apb_timer: APB reads go through a scoreboard queue, counter timing is checked per cycle.
// Expected irq/IE behaviour follows whether APB_TIMER_IRQ_EN is defined for the build.
module tb_apb_timer;
`ifdef APB_TIMER_IRQ_EN
    localparam logic [31:0] IE_BIT = 32'h0000_0004;
    localparam logic [31:0] IRQ_EXP = 32'd1;
`else
    localparam logic [31:0] IE_BIT = 32'h0000_0000;
    localparam logic [31:0] IRQ_EXP = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        preset;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        irq;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    int          seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    apb_timer dut (
        .PCLK   (clk),
        .PRESET (preset),
        .PSEL   (psel),
        .PENABLE(penable),
        .PWRITE (pwrite),
        .PADDR  (paddr),
        .PWDATA (pwdata),
        .PRDATA (prdata),
        .PREADY (pready),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One APB transfer; returns just after the edge on which it commits.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rd, input string tag);
        int cyc;
        logic [31:0] exp_v;
        if (!wr) exp_q.push_back(exp_rd);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(negedge clk);
        check({tag, " setup_pready"}, 32'(pready), 32'd0);
        @(posedge clk); #1;
        penable = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!pready && cyc < 6);
        check({tag, " pready_cycle"}, 32'(cyc), 32'd2);
        if (!wr) begin
            exp_v = exp_q.pop_front();
            check({tag, " prdata"}, prdata, exp_v);
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input string tag);
        apb_xfer(1'b1, addr, data, 32'd0, tag);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        apb_xfer(1'b0, addr, 32'd0, exp, tag);
    endtask

    task automatic wait_cnt(input logic [31:0] cnt_v, input logic [31:0] psc_v, input string tag);
        int n;
        n = 0;
        while (!(dut.cnt_q == cnt_v && dut.psc_cnt_q == psc_v) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, " reached"}, 32'(n < 200), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c4;
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0;
        @(negedge clk);
        check("rst pready", 32'(pready), 32'd0);
        check("rst irq", 32'(irq), 32'd0);
        check("rst prdata", prdata, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        preset = 1'b0;
        rd(32'h0, 32'h0, "rst ctrl");
        rd(32'h4, 32'h0, "rst psc");
        rd(32'h8, 32'h0, "rst arr");
        rd(32'hC, 32'h0, "rst cnt");

        // Handshake and PRDATA return-to-zero
        wr(32'h8, 32'h3, "wr arr");
        rd(32'h8, 32'h3, "rd arr");
        @(negedge clk);
        check("post pready", 32'(pready), 32'd0);
        check("post prdata", prdata, 32'd0);

        // Aborted write: PSEL dropped during the wait state
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h7;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge clk);
        check("abort pready1", 32'(pready), 32'd0);
        @(negedge clk);
        check("abort pready2", 32'(pready), 32'd0);
        rd(32'h8, 32'h3, "abort arr");

        // Counting: PSC=1, ARR=3
        wr(32'h4, 32'h1, "wr psc");
        wr(32'h0, 32'h1, "wr en");
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check($sformatf("seq cnt%0d", k), dut.cnt_q, 32'(seq[k]));
            check($sformatf("seq ovf%0d", k), 32'(dut.ovf_q), (k == 8) ? 32'd1 : 32'd0);
        end
        rd(32'h0, 32'h101, "rd ctrl ovf");

        // CLR committing while CNT=2 (a tick would also occur on that edge)
        wait_cnt(32'd1, 32'd0, "clr");
        wr(32'h0, 32'h3, "wr clr");
        @(negedge clk);
        check("clr cnt", dut.cnt_q, 32'd0);
        check("clr psc", dut.psc_cnt_q, 32'd0);
        check("clr ovf", 32'(dut.ovf_q), 32'd1);
        @(negedge clk);
        check("clr psc+1", dut.psc_cnt_q, 32'd1);
        @(negedge clk);
        check("clr resume", dut.cnt_q, 32'd1);

        // PSC=0, ARR=0: overflow every cycle
        wr(32'h0, 32'h102, "stop clr w1c");
        wr(32'h4, 32'h0, "wr psc0");
        wr(32'h8, 32'h0, "wr arr0");
        rd(32'h0, 32'h0, "ctrl cleared");
        wr(32'h0, 32'h1, "en psc0");
        @(negedge clk);
        check("b0 ovf0", 32'(dut.ovf_q), 32'd0);
        @(negedge clk);
        check("b0 ovf1", 32'(dut.ovf_q), 32'd1);
        check("b0 cnt", dut.cnt_q, 32'd0);
        wr(32'h0, 32'h101, "w1c vs ovf");
        check("w1c set wins", 32'(dut.ovf_q), 32'd1);
        wr(32'h0, 32'h100, "w1c stop");
        wr(32'h0, 32'h100, "w1c idle");
        rd(32'h0, 32'h0, "w1c cleared");

        // Lower ARR below the running count
        wr(32'h4, 32'h7, "wr psc7");
        wr(32'h8, 32'd10, "wr arr10");
        wr(32'h0, 32'h1, "en arr");
        wait_cnt(32'd5, 32'd0, "cnt5");
        wr(32'h8, 32'h1, "lower arr");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
        end
        c4 = dut.cnt_q;
        check("arr hold", c4, 32'd5);
        @(negedge clk);
        check("arr reload", dut.cnt_q, 32'd0);
        check("arr ovf", 32'(dut.ovf_q), 32'd1);

        // CNT is read-only
        wr(32'h0, 32'h102, "stop2");
        wr(32'hC, 32'h55, "wr cnt");
        rd(32'hC, 32'h0, "cnt ro");

        // Interrupt
        wr(32'h4, 32'h0, "irq psc");
        wr(32'h8, 32'h0, "irq arr");
        wr(32'h0, 32'h5, "irq en");
        @(negedge clk);
        check("irq low", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq high", 32'(irq), IRQ_EXP);
        rd(32'h0, 32'h101 | IE_BIT, "irq ctrl");
        wr(32'h0, 32'h4, "irq stop");
        check("irq held", 32'(irq), IRQ_EXP);
        wr(32'h0, 32'h104, "irq w1c");
        @(negedge clk);
        check("irq cleared", 32'(irq), 32'd0);
        rd(32'h0, IE_BIT, "ie readback");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
